// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-slot state type for the
// single-master initiator.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    A_EMPTY,
    A_ACTIVE,
    A_CANCELLED
  } a_state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master initiator: valid/ready commands become pipelined
// single-beat word transfers, with wait-state and two-cycle ERROR handling.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  a_state_t          a_state_q, a_state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic              d_active_q, d_active_d;
  logic              d_write_q, d_write_d;
  logic              errflag_q, errflag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic              accept;
  logic              err_first;
  logic [ADDR_W-1:0] word_addr;
  logic [1:0]        unused_byte_lane;

  assign word_addr        = {cmd_addr[ADDR_W-1:2], 2'b00};
  assign unused_byte_lane = cmd_addr[1:0];

  assign cmd_ready = !HRESET && !errflag_q &&
                     (a_state_q == A_EMPTY || (a_state_q == A_ACTIVE && HREADY));
  assign accept    = cmd_valid && cmd_ready;
  assign err_first = !HREADY && d_active_q && (HRESP == HRESP_ERROR) && !errflag_q;

  always_comb begin
    a_state_d   = a_state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    a_wdata_d   = a_wdata_q;
    hwdata_d    = hwdata_q;
    d_active_d  = d_active_q;
    d_write_d   = d_write_q;
    errflag_d   = errflag_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;

    if (HREADY) begin
      if (d_active_q) begin
        rsp_valid_d = 1'b1;
        rsp_error_d = HRESP;
        rsp_rdata_d = (!d_write_q && HRESP == HRESP_OKAY) ? HRDATA : '0;
      end
      errflag_d  = 1'b0;
      d_active_d = 1'b0;
      case (a_state_q)
        A_ACTIVE: begin
          d_active_d = 1'b1;
          d_write_d  = hwrite_q;
          hwdata_d   = a_wdata_q;
          a_state_d  = A_EMPTY;
          htrans_d   = HTRANS_IDLE;
        end
        A_CANCELLED: begin
          a_state_d = A_ACTIVE;
          htrans_d  = HTRANS_NONSEQ;
        end
        default: ;
      endcase
      if (accept) begin
        a_state_d = A_ACTIVE;
        htrans_d  = HTRANS_NONSEQ;
        haddr_d   = word_addr;
        hwrite_d  = cmd_write;
        a_wdata_d = cmd_wdata;
      end
    end else begin
      if (err_first) begin
        errflag_d = 1'b1;
        if (a_state_q == A_ACTIVE) begin
          a_state_d = A_CANCELLED;
          htrans_d  = HTRANS_IDLE;
        end
      end
      // A command taken on the first ERROR edge is parked as cancelled so it
      // never appears on the bus during the second ERROR cycle.
      if (accept) begin
        a_state_d = err_first ? A_CANCELLED : A_ACTIVE;
        htrans_d  = err_first ? HTRANS_IDLE : HTRANS_NONSEQ;
        haddr_d   = word_addr;
        hwrite_d  = cmd_write;
        a_wdata_d = cmd_wdata;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_state_q   <= A_EMPTY;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      a_wdata_q   <= '0;
      hwdata_q    <= '0;
      d_active_q  <= 1'b0;
      d_write_q   <= 1'b0;
      errflag_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      a_state_q   <= a_state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      a_wdata_q   <= a_wdata_d;
      hwdata_q    <= hwdata_d;
      d_active_q  <= d_active_d;
      d_write_q   <= d_write_d;
      errflag_q   <= errflag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign busy      = (a_state_q != A_EMPTY) || d_active_q || rsp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized scoreboard bench for ahb_lite_master with a behavioural slave
// and a memory-level reference model.
module tb_ahb_lite_master;
  import ahb_pkg::*;

  logic        HCLK, HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ahb_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; } iss_t;
  typedef struct { logic [31:0] rdata; logic err; int acc_cyc; bit lat_chk; } rsp_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int unsigned max_wait = 0;
  int          force_wait = -1;
  bit          lat_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h3C3C_1234;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial forever @(posedge HCLK) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus: hold a command until accepted; expected bus and response
  // traffic is derived from the memory model at acceptance.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   n = 0;
    bit   done = 1'b0;
    iss_t ie;
    rsp_t re;
    logic [31:0] al;
    al = a & 32'hFFFF_FFFC;
    while (!done) begin
      @(negedge HCLK);
      #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      #3;
      if (HTRANS == HTRANS_NONSEQ && !HREADY)
        check("cmd_ready_while_stalled", 64'(cmd_ready), 64'd0);
      if (cmd_ready) begin
        done = 1'b1;
        ie.addr = al; ie.write = w; ie.wdata = d;
        iss_q.push_back(ie);
        re.err = is_err(al);
        re.rdata = (w || re.err) ? 32'h0 : ref_rd(al);
        re.acc_cyc = cyc;
        re.lat_chk = lat_mode && !re.err && max_wait == 0 && force_wait < 0;
        rsp_q.push_back(re);
        if (w && !re.err) ref_mem[al] = d;
      end else if (++n > 60) begin
        fail_now("accept_timeout");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge HCLK);
      #1 cmd_valid = 1'b0;
    end
  endtask

  // Behavioural slave plus bus-protocol checks, evaluated once per cycle.
  initial begin
    bit          dp = 1'b0, dp_w = 1'b0, dp_err = 1'b0, err_ph = 1'b0;
    logic [31:0] dp_addr = '0, dp_wd = '0;
    int          waits = 0;
    bit          prev_rst = 1'b1;
    logic        prev_ready = 1'b1, prev_resp = 1'b0;
    logic [34:0] prev_bus = '0;
    logic [31:0] prev_wd = '0;
    iss_t        e;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp = 1'b0; err_ph = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0;
        prev_rst = 1'b1;
      end else begin
        if (!prev_rst && !prev_ready) begin
          check("hwdata_hold", 64'(HWDATA), 64'(prev_wd));
          if (prev_bus[2:1] == HTRANS_NONSEQ && !prev_resp)
            check("addr_phase_hold", 64'({HADDR, HTRANS, HWRITE}), 64'(prev_bus));
        end
        check("htrans_legal", 64'(HTRANS == HTRANS_BUSY || HTRANS == HTRANS_SEQ), 64'd0);
        HRDATA = $urandom; HRESP = 1'b0; HREADY = 1'b1;
        if (dp) begin
          if (err_ph) begin
            HRESP = 1'b1;
            check("htrans_idle_err2", 64'(HTRANS), 64'(HTRANS_IDLE));
          end else if (waits > 0) begin
            HREADY = 1'b0; waits--;
          end else if (dp_err) begin
            HREADY = 1'b0; HRESP = 1'b1;
          end else if (!dp_w) begin
            HRDATA = slv_mem.exists(dp_addr) ? slv_mem[dp_addr] : init_val(dp_addr);
          end
        end
        if (HREADY) begin
          if (dp && dp_w) begin
            check("hwdata", 64'(HWDATA), 64'(dp_wd));
            if (!dp_err) slv_mem[dp_addr] = HWDATA;
          end
          dp = 1'b0; err_ph = 1'b0;
          if (HTRANS == HTRANS_NONSEQ) begin
            if (iss_q.size() == 0) fail_now("unexpected_nonseq");
            else begin
              e = iss_q.pop_front();
              check("addr_phase", 64'({HWRITE, HADDR}), 64'({e.write, e.addr}));
              dp = 1'b1; dp_addr = HADDR; dp_w = HWRITE; dp_wd = e.wdata;
              dp_err = is_err(HADDR);
              waits = (force_wait >= 0) ? force_wait : int'($urandom_range(0, max_wait));
            end
          end
        end else if (HRESP) begin
          err_ph = 1'b1;
        end
        prev_rst = 1'b0;
      end
      prev_ready = HREADY; prev_resp = HRESP;
      prev_bus = {HADDR, HTRANS, HWRITE}; prev_wd = HWDATA;
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  initial begin
    rsp_t r;
    forever begin
      @(negedge HCLK);
      if (rsp_valid) begin
        check("busy_with_rsp", 64'(busy), 64'd1);
        if (rsp_q.size() == 0) fail_now("unexpected_rsp");
        else begin
          r = rsp_q.pop_front();
          check("rsp_error", 64'(rsp_error), 64'(r.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          if (r.lat_chk) check("rsp_latency", 64'(cyc - r.acc_cyc), 64'd3);
        end
      end
    end
  end

  initial begin
    int k;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    ref_mem[32'h0] = 32'h0000_A5A5; slv_mem[32'h0] = 32'h0000_A5A5;
    ref_mem[32'h4] = 32'h0000_5A5A; slv_mem[32'h4] = 32'h0000_5A5A;
    repeat (3) @(negedge HCLK);
    #1;
    check("reset_bus", 64'({HADDR, HTRANS, HWRITE}), 64'd0);
    check("reset_hwdata", 64'(HWDATA), 64'd0);
    check("reset_rsp", 64'({rsp_valid, rsp_error, rsp_rdata}), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("bus_constants", 64'({HSIZE, HBURST, HPROT, HMASTLOCK}),
          64'({HSIZE_WORD, HBURST_SINGLE, HPROT_DEFAULT, 1'b0}));
    HRESET = 1'b0;

    lat_mode = 1'b1; max_wait = 0; force_wait = -1;
    issue(1'b1, 32'h5300_0004, 32'h0000_0001);
    idle(4);
    issue(1'b0, 32'h0000_0000, 32'h0);
    issue(1'b0, 32'h0000_0004, 32'h0);
    idle(4);
    issue(1'b1, 32'h5300_0007, 32'h0000_0077);
    issue(1'b0, 32'h5300_0004, 32'h0);
    idle(4);

    lat_mode = 1'b0; force_wait = 3;
    issue(1'b1, 32'h5300_0010, 32'h1111_2222);
    issue(1'b1, 32'h5300_0014, 32'h3333_4444);
    issue(1'b0, 32'h5300_0010, 32'h0);
    idle(8);

    force_wait = 0;
    issue(1'b1, 32'hE000_0010, 32'hDEAD_BEEF);
    issue(1'b1, 32'h5300_0008, 32'hCAFE_0008);
    issue(1'b0, 32'h5300_0008, 32'h0);
    issue(1'b0, 32'hE000_0020, 32'h0);
    issue(1'b0, 32'h5300_0014, 32'h0);
    idle(6);

    force_wait = -1; max_wait = 3;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'h5300_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      issue($urandom_range(0, 1) == 1, a, $urandom);
    end
    idle(1);
    k = 0;
    while (rsp_q.size() != 0 && k < 300) begin @(negedge HCLK); k++; end
    if (rsp_q.size() != 0) fail_now("drain_timeout");

    force_wait = 6;
    issue(1'b0, 32'h5300_0020, 32'h0);
    idle(4);
    @(negedge HCLK);
    #1 HRESET = 1'b1;
    rsp_q.delete(); iss_q.delete();
    #3 check("cmd_ready_in_reset", 64'(cmd_ready), 64'd0);
    @(negedge HCLK);
    #1;
    check("post_reset_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_rsp", 64'(rsp_valid), 64'd0);
    HRESET = 1'b0;
    #3 check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    force_wait = -1; max_wait = 1;
    issue(1'b1, 32'h5300_0040, 32'h0BAD_F00D);
    issue(1'b0, 32'h5300_0040, 32'h0);
    idle(1);
    k = 0;
    while (rsp_q.size() != 0 && k < 300) begin @(negedge HCLK); k++; end
    if (rsp_q.size() != 0) fail_now("final_drain_timeout");
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
